traffic_light_ctrl: RTL and testbench

- Sequences the vehicle signal through GREEN → YELLOW → RED using a clock prescaler and per-phase tick counters.
- Optionally holds GREEN until a pedestrian request is latched.
- Its registered `red_trffc_light` and `ylw_trffc_light` outputs drive the crosswalk walk/stop block directly.
- Sits between the board clock/button inputs and the crosswalk and light drivers.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/traffic_light_ctrl_tick_prescaler.sv | 22 ++
 rtl/traffic_light_ctrl.sv | 85 ++++++++
 tb/tb_traffic_light_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared FSM state encoding, default phase lengths and sizing helper
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    localparam int DEF_TICK_DIV  = 50_000_000;
    localparam int DEF_GRN_TICKS = 10;
    localparam int DEF_YLW_TICKS = 3;
    localparam int DEF_RED_TICKS = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_prescaler.sv
// tick_prescaler: free-running divider, tick high on the last count of each TICK_DIV window
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] cnt;

    assign tick = (cnt == PW'(TICK_DIV - 1));

    // wrap at TICK_DIV-1; phase changes never touch this counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= tick ? '0 : cnt + PW'(1);
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: GREEN->YELLOW->RED sequencer; PED_BUTTON_EN holds GREEN until a latched request
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int GRN_TICKS = DEF_GRN_TICKS,
    parameter int YLW_TICKS = DEF_YLW_TICKS,
    parameter int RED_TICKS = DEF_RED_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_req,
    output logic red_trffc_light,
    output logic ylw_trffc_light,
    output logic grn_trffc_light,
    output logic ped_pending
);

    localparam int MAX_TICKS = max3(GRN_TICKS, YLW_TICKS, RED_TICKS);
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    logic             tick;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, last_cnt;
    logic             at_last, grn_ok, advance;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign last_cnt = (state == ST_GREEN)  ? CNT_W'(GRN_TICKS - 1) :
                      (state == ST_YELLOW) ? CNT_W'(YLW_TICKS - 1) :
                                             CNT_W'(RED_TICKS - 1);
    assign at_last  = (cnt == last_cnt);

`ifdef PED_BUTTON_EN
    assign grn_ok = ped_pending;
`else
    assign grn_ok = 1'b1;
`endif

    assign advance = tick && at_last && ((state != ST_GREEN) || grn_ok);

    // next state and phase count; GREEN count saturates while waiting for a request
    always_comb begin
        state_nxt = !advance               ? state     :
                    (state == ST_RED)      ? ST_GREEN  :
                    (state == ST_GREEN)    ? ST_YELLOW : ST_RED;
        cnt_nxt   = advance                ? '0              :
                    (tick && !at_last)     ? cnt + CNT_W'(1) : cnt;
    end

    // state, counter and one-hot lights registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_RED;
            cnt             <= '0;
            red_trffc_light <= 1'b1;
            ylw_trffc_light <= 1'b0;
            grn_trffc_light <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            red_trffc_light <= (state_nxt == ST_RED);
            ylw_trffc_light <= (state_nxt == ST_YELLOW);
            grn_trffc_light <= (state_nxt == ST_GREEN);
        end
    end

`ifdef PED_BUTTON_EN
    // latch requests outside RED; entering RED serves them and clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ped_pending <= 1'b0;
        else     ped_pending <= (advance && state == ST_YELLOW) ? 1'b0 :
                                (ped_req && state != ST_RED)    ? 1'b1 : ped_pending;
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_pending    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: table-driven checks of light sequencing, request latch and async reset
module tb_traffic_light_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ped_req = 1'b0;
    logic red, ylw, grn, pend;
    int   total = 0;
    int   bad = 0;
    int   cyc;
    bit   rand_on = 1'b0;

    typedef struct {
        int    at;
        int    act;
        logic  r, y, g, p;
        string nm;
    } vec_t;

    vec_t tbl[$];

    traffic_light_ctrl #(
        .TICK_DIV  (4),
        .GRN_TICKS (3),
        .YLW_TICKS (2),
        .RED_TICKS (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ped_req         (ped_req),
        .red_trffc_light (red),
        .ylw_trffc_light (ylw),
        .grn_trffc_light (grn),
        .ped_pending     (pend)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic [2:0] prev;
    bit         prev_ok = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (!$onehot({red, ylw, grn})) begin
                bad++;
                $display("FAIL onehot: cyc=%0d got rgy=%b%b%b want exactly one high", cyc, red, grn, ylw);
            end
            if (prev_ok && {red, ylw, grn} !== prev) begin
                total++;
                if (cyc % 4 != 0) begin
                    bad++;
                    $display("FAIL tick_align: change at cyc=%0d (cyc%%4=%0d) want 0", cyc, cyc % 4);
                end
            end
        end
        prev    = {red, ylw, grn};
        prev_ok = !rst;
    end

    task automatic chk(input string nm, input logic r, input logic y, input logic g, input logic p);
        total++;
        if ({red, ylw, grn, pend} !== {r, y, g, p}) begin
            bad++;
            $display("FAIL %s: cyc=%0d got r/y/g/p=%b%b%b%b want %b%b%b%b",
                     nm, cyc, red, ylw, grn, pend, r, y, g, p);
        end
    endtask

    task automatic add(input int at, input int act, input logic r, input logic y,
                       input logic g, input logic p, input string nm);
        vec_t v;
        v.at = at; v.act = act; v.r = r; v.y = y; v.g = g; v.p = p; v.nm = nm;
        tbl.push_back(v);
    endtask

    task automatic wait_until(input int at);
        while (cyc < at) begin
            @(negedge clk);
            if (rand_on) ped_req = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef PED_BUTTON_EN
        add(1,   0, 1, 0, 0, 0, "red_start");
        add(19,  0, 1, 0, 0, 0, "red_last");
        add(20,  0, 0, 0, 1, 0, "grn_on");
        add(100, 0, 0, 0, 1, 0, "grn_hold100");
        add(230, 1, 0, 0, 1, 0, "grn_hold230");
        add(231, 0, 0, 0, 1, 1, "pend_set");
        add(232, 0, 0, 1, 0, 1, "ylw_on_tick");
        add(239, 0, 0, 1, 0, 1, "ylw_last");
        add(240, 0, 1, 0, 0, 0, "red_clears_pend");
        add(259, 0, 1, 0, 0, 0, "red2_last");
        add(260, 1, 0, 0, 1, 0, "grn2_cycle1");
        add(262, 0, 0, 0, 1, 1, "grn2_pend");
        add(271, 0, 0, 0, 1, 1, "grn2_cycle12");
        add(272, 0, 0, 1, 0, 1, "grn2_exit12");
        add(280, 0, 1, 0, 0, 0, "red3_on");
        add(285, 1, 1, 0, 0, 0, "red3_req");
        add(286, 0, 1, 0, 0, 0, "red_req_ignored");
        add(300, 0, 0, 0, 1, 0, "grn3_on");
        add(400, 1, 0, 0, 1, 0, "grn3_held");
        add(401, 0, 0, 0, 1, 1, "grn3_pend");
        add(404, 0, 0, 1, 0, 1, "ylw3_on");
        add(406, 2, 0, 1, 0, 1, "ylw3_mid");
        add(19,  0, 1, 0, 0, 0, "post_rst_red_last");
        add(20,  0, 0, 0, 1, 0, "post_rst_grn");
        add(250, 0, 0, 0, 1, 0, "post_rst_grn_held");
`else
        rand_on = 1'b1;
        add(1,  0, 1, 0, 0, 0, "red_start");
        add(19, 0, 1, 0, 0, 0, "red_last");
        add(20, 0, 0, 0, 1, 0, "grn_on");
        add(31, 0, 0, 0, 1, 0, "grn_last");
        add(32, 0, 0, 1, 0, 0, "ylw_on");
        add(39, 0, 0, 1, 0, 0, "ylw_last");
        add(40, 0, 1, 0, 0, 0, "red2_on");
        add(59, 0, 1, 0, 0, 0, "red2_last");
        add(60, 0, 0, 0, 1, 0, "grn2_on");
        add(71, 0, 0, 0, 1, 0, "grn2_last");
        add(72, 0, 0, 1, 0, 0, "ylw2_on");
        add(74, 2, 0, 1, 0, 0, "ylw2_mid");
        add(19, 0, 1, 0, 0, 0, "post_rst_red_last");
        add(20, 0, 0, 0, 1, 0, "post_rst_grn");
        add(32, 0, 0, 1, 0, 0, "post_rst_ylw");
        add(40, 0, 1, 0, 0, 0, "post_rst_red");
`endif
        #1 rst = 1'b1;
        #1 chk("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            wait_until(tbl[i].at);
            chk(tbl[i].nm, tbl[i].r, tbl[i].y, tbl[i].g, tbl[i].p);
            if (tbl[i].act == 1) begin
                ped_req = 1'b1;
                @(negedge clk);
                ped_req = 1'b0;
            end else if (tbl[i].act == 2) begin
                #2 rst = 1'b1;
                #1 chk("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end
        rand_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
